// File: rtl/branch_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Predictor entries use a fixed maximum-width tag; narrower tags are zero-extended.
package branch_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b10;
   localparam ctr_t CTR_ST  = 2'b11;

   localparam int TAG_MAX_W = 30;

   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
      logic [31:0]          target;
      ctr_t                 ctr;
   } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
// force_strong_i (unconditional jumps) pins the counter at strongly taken.
module sat_counter2
   import branch_pkg::*;
(
   input  ctr_t ctr_i,
   input  logic taken_i,
   input  logic force_strong_i,
   output ctr_t ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (force_strong_i) begin
         ctr_o = CTR_ST;
      end else if (taken_i) begin
         if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with target storage, misprediction redirect
// generation and a running count of redirects.
module branch_predictor
   import branch_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] fetch_pc_i,
   output logic        pred_taken_o,
   output logic [31:0] pred_target_o,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic        upd_uncond_i,
   input  logic        upd_taken_i,
   input  logic [31:0] upd_target_i,
   input  logic        upd_pred_taken_i,
   input  logic [31:0] upd_pred_target_i,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic [31:0] mispred_cnt_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   bp_entry_t entry_q [ENTRIES];
   bp_entry_t entry_d [ENTRIES];
   logic [31:0] cnt_q, cnt_d;

   logic [IDX_W-1:0]     fetch_idx, upd_idx;
   logic [TAG_W-1:0]     fetch_tag_raw, upd_tag_raw;
   logic [TAG_MAX_W-1:0] fetch_tag, upd_tag;
   bp_entry_t            fetch_entry, upd_entry;
   logic                 fetch_hit, upd_hit, upd_eff_taken;
   ctr_t                 upd_ctr_next;

   assign fetch_idx     = fetch_pc_i[IDX_W+1:2];
   assign fetch_tag_raw = fetch_pc_i[31:IDX_W+2];
   assign fetch_tag     = TAG_MAX_W'(fetch_tag_raw);
   assign upd_idx       = upd_pc_i[IDX_W+1:2];
   assign upd_tag_raw   = upd_pc_i[31:IDX_W+2];
   assign upd_tag       = TAG_MAX_W'(upd_tag_raw);

   // Lookup reads only registered state, so a same-cycle update is not bypassed
   assign fetch_entry   = entry_q[fetch_idx];
   assign fetch_hit     = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
   assign pred_taken_o  = fetch_hit && fetch_entry.ctr[1];
   assign pred_target_o = pred_taken_o ? fetch_entry.target : fetch_pc_i + 32'd4;

   assign redirect_o    = upd_valid_i &&
                          ((upd_taken_i != upd_pred_taken_i) ||
                           (upd_taken_i && (upd_target_i != upd_pred_target_i)));
   assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;
   assign mispred_cnt_o = cnt_q;

   assign upd_entry     = entry_q[upd_idx];
   assign upd_hit       = upd_entry.valid && (upd_entry.tag == upd_tag);
   assign upd_eff_taken = upd_taken_i | upd_uncond_i;

   sat_counter2 u_sat_counter2 (
      .ctr_i          (upd_entry.ctr),
      .taken_i        (upd_eff_taken),
      .force_strong_i (upd_uncond_i),
      .ctr_o          (upd_ctr_next)
   );

   // Not-taken misses never allocate, keeping the table for taken branches
   always_comb begin
      entry_d = entry_q;
      cnt_d   = cnt_q + {31'd0, redirect_o};
      if (upd_valid_i) begin
         if (upd_hit) begin
            entry_d[upd_idx].ctr = upd_ctr_next;
            if (upd_eff_taken) entry_d[upd_idx].target = upd_target_i;
         end else if (upd_eff_taken) begin
            entry_d[upd_idx].valid  = 1'b1;
            entry_d[upd_idx].tag    = upd_tag;
            entry_d[upd_idx].target = upd_target_i;
            entry_d[upd_idx].ctr    = upd_uncond_i ? CTR_ST : CTR_WT;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entry_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
         end
         cnt_q <= '0;
      end else begin
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: expected outputs are queued per step
// and popped when the outputs are sampled mid-cycle.
module tb_branch_predictor;

   typedef struct {
      string       tag;
      logic        predTaken;
      logic [31:0] predTarget;
      logic        redirect;
      logic [31:0] redirectPc;
      logic [31:0] cnt;
   } expect_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] fetch_pc_i;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_uncond_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
   logic        upd_pred_taken_i;
   logic [31:0] upd_pred_target_i;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic [31:0] mispred_cnt_o;

   expect_t scoreboard[$];
   int assertCount = 0;
   int failCount   = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .fetch_pc_i        (fetch_pc_i),
      .pred_taken_o      (pred_taken_o),
      .pred_target_o     (pred_target_o),
      .upd_valid_i       (upd_valid_i),
      .upd_pc_i          (upd_pc_i),
      .upd_uncond_i      (upd_uncond_i),
      .upd_taken_i       (upd_taken_i),
      .upd_target_i      (upd_target_i),
      .upd_pred_taken_i  (upd_pred_taken_i),
      .upd_pred_target_i (upd_pred_target_i),
      .redirect_o        (redirect_o),
      .redirect_pc_o     (redirect_pc_o),
      .mispred_cnt_o     (mispred_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic applyStimulus(input logic [31:0] fetch, input logic valid,
                                input logic [31:0] pc, input logic uncond,
                                input logic taken, input logic [31:0] target,
                                input logic pTaken, input logic [31:0] pTarget);
      fetch_pc_i        = fetch;
      upd_valid_i       = valid;
      upd_pc_i          = pc;
      upd_uncond_i      = uncond;
      upd_taken_i       = taken;
      upd_target_i      = target;
      upd_pred_taken_i  = pTaken;
      upd_pred_target_i = pTarget;
   endtask

   task automatic expectOut(input string tag, input logic pt, input logic [31:0] ptg,
                            input logic rd, input logic [31:0] rpc, input logic [31:0] cnt);
      expect_t e;
      e.tag = tag; e.predTaken = pt; e.predTarget = ptg;
      e.redirect = rd; e.redirectPc = rpc; e.cnt = cnt;
      scoreboard.push_back(e);
   endtask

   task automatic checkField(input string tag, input string field,
                             input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s.%s observed=%08h expected=%08h", tag, field, observed, expected);
      end
   endtask

   task automatic checkOutput();
      expect_t e;
      if (scoreboard.size() == 0) begin
         assertCount++;
         failCount++;
         $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = scoreboard.pop_front();
      checkField(e.tag, "pred_taken",  {31'd0, pred_taken_o}, {31'd0, e.predTaken});
      checkField(e.tag, "pred_target", pred_target_o,         e.predTarget);
      checkField(e.tag, "redirect",    {31'd0, redirect_o},   {31'd0, e.redirect});
      checkField(e.tag, "redirect_pc", redirect_pc_o,         e.redirectPc);
      checkField(e.tag, "cnt",         mispred_cnt_o,         e.cnt);
   endtask

   // Drive at posedge+1, sample at posedge+3, then advance one cycle
   task automatic runStep(input string tag,
                          input logic [31:0] fetch, input logic valid,
                          input logic [31:0] pc, input logic uncond,
                          input logic taken, input logic [31:0] target,
                          input logic pTaken, input logic [31:0] pTarget,
                          input logic ept, input logic [31:0] eptg,
                          input logic erd, input logic [31:0] erpc,
                          input logic [31:0] ecnt);
      applyStimulus(fetch, valid, pc, uncond, taken, target, pTaken, pTarget);
      expectOut(tag, ept, eptg, erd, erpc, ecnt);
      #2;
      checkOutput();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni = 1'b0;
      applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      expectOut("reset", 1'b0, 32'h104, 1'b0, 32'h4, 32'd0);
      #2;
      checkOutput();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      //       tag            fetch          v  pc        u  t  target      pt pTarget     ePT eTarget       eRd eRpc        eCnt
      runStep("first_taken",  32'h100,      1, 32'h100,  0, 1, 32'h80,     0, 32'h0,     0, 32'h104,      1, 32'h80,     0);
      runStep("trained",      32'h100,      0, 32'h0,    0, 0, 32'h0,      0, 32'h0,     1, 32'h80,       0, 32'h4,      1);
      runStep("nt_1",         32'h100,      1, 32'h100,  0, 0, 32'h0,      1, 32'h80,    1, 32'h80,       1, 32'h104,    1);
      runStep("nt_2",         32'h100,      1, 32'h100,  0, 0, 32'h0,      0, 32'h0,     0, 32'h104,      0, 32'h104,    2);
      runStep("tk_1",         32'h100,      1, 32'h100,  0, 1, 32'h80,     0, 32'h0,     0, 32'h104,      1, 32'h80,     2);
      runStep("tk_2",         32'h100,      1, 32'h100,  0, 1, 32'h80,     0, 32'h0,     0, 32'h104,      1, 32'h80,     3);
      runStep("tk_3",         32'h100,      1, 32'h100,  0, 1, 32'h80,     1, 32'h80,    1, 32'h80,       0, 32'h80,     4);
      runStep("tk_sat",       32'h100,      1, 32'h100,  0, 1, 32'h80,     1, 32'h80,    1, 32'h80,       0, 32'h80,     4);
      runStep("nt_from_st",   32'h100,      1, 32'h100,  0, 0, 32'h0,      1, 32'h80,    1, 32'h80,       1, 32'h104,    4);
      runStep("still_taken",  32'h100,      0, 32'h0,    0, 0, 32'h0,      0, 32'h0,     1, 32'h80,       0, 32'h4,      5);
      runStep("alias_alloc",  32'h140,      1, 32'h140,  0, 1, 32'h500,    0, 32'h0,     0, 32'h144,      1, 32'h500,    5);
      runStep("alias_old",    32'h100,      0, 32'h0,    0, 0, 32'h0,      0, 32'h0,     0, 32'h104,      0, 32'h4,      6);
      runStep("alias_new",    32'h140,      0, 32'h0,    0, 0, 32'h0,      0, 32'h0,     1, 32'h500,      0, 32'h4,      6);
      runStep("same_cycle",   32'h200,      1, 32'h200,  0, 1, 32'h240,    0, 32'h0,     0, 32'h204,      1, 32'h240,    6);
      runStep("next_cycle",   32'h200,      0, 32'h0,    0, 0, 32'h0,      0, 32'h0,     1, 32'h240,      0, 32'h4,      7);
      runStep("uncond_alloc", 32'h0,        1, 32'h304,  1, 1, 32'h600,    0, 32'h0,     0, 32'h4,        1, 32'h600,    7);
      runStep("uncond_nt",    32'h0,        1, 32'h304,  0, 0, 32'h0,      1, 32'h600,   0, 32'h4,        1, 32'h308,    8);
      runStep("uncond_fetch", 32'h304,      0, 32'h0,    0, 0, 32'h0,      0, 32'h0,     1, 32'h600,      0, 32'h4,      9);
      runStep("wrong_target", 32'h2F0,      1, 32'h2F0,  0, 1, 32'h340,    1, 32'h300,   0, 32'h2F4,      1, 32'h340,    9);
      runStep("idle_hold",    32'hFFFF_FFFC,0, 32'h400,  0, 1, 32'h700,    0, 32'h0,     0, 32'h0,        0, 32'h700,    10);
      runStep("no_alloc",     32'h400,      0, 32'h0,    0, 0, 32'h0,      0, 32'h0,     0, 32'h404,      0, 32'h4,      10);
      runStep("wt_trained",   32'h2F0,      0, 32'h0,    0, 0, 32'h0,      0, 32'h0,     1, 32'h340,      0, 32'h4,      10);

      // Asynchronous reset mid-run with a pending update that must be discarded
      applyStimulus(32'h2F0, 1'b1, 32'h2F0, 1'b0, 1'b1, 32'h340, 1'b0, 32'h0);
      rst_ni = 1'b0;
      expectOut("async_reset", 1'b0, 32'h2F4, 1'b1, 32'h340, 32'd0);
      #1;
      checkOutput();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      runStep("post_reset",   32'h2F0,      0, 32'h0,    0, 0, 32'h0,      0, 32'h0,     0, 32'h2F4,      0, 32'h4,      0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor and redirect generator for the RISC-V core.
- Each cycle it predicts direction and target for the fetch PC.
- When a control-transfer instruction resolves in execute, it receives the actual outcome (the taken/not-taken decision from the branch-select path plus the computed target).
- It trains its tables, flags mispredictions and supplies the corrected PC to the PC mux.

Parameters:
- ENTRIES, 16, number of predictor entries; power of 2, ≥2.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
- TAG_W, 30-IDX_W, tag width = pc[31:IDX_W+2].

Ports:
- clk_i  in  1  core clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- fetch_pc_i  in  32  PC being fetched this cycle
- pred_taken_o  out  1  predicted taken for fetch_pc_i
- pred_target_o  out  32  predicted target; fetch_pc_i+4 when not predicted taken
- upd_valid_i  in  1  resolved control-transfer instruction present in execute this cycle
- upd_pc_i  in  32  PC of the resolved instruction
- upd_uncond_i  in  1  resolved instruction is JAL/JALR (always taken)
- upd_taken_i  in  1  actual outcome (final branch select)
- upd_target_i  in  32  actual target address
- upd_pred_taken_i  in  1  prediction carried down the pipe for this instruction
- upd_pred_target_i  in  32  predicted target carried down the pipe
- redirect_o  out  1  misprediction; flush younger stages
- redirect_pc_o  out  32  corrected next PC
- mispred_cnt_o  out  32  count of redirects since reset

Behaviour:
- Entry contents: valid (1), tag (TAG_W), target (32), ctr (2-bit saturating counter).
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Lookup:
  - Combinational read of registered state.
  - hit = valid[idx] && tag match.
  - pred_taken_o = hit && ctr[1].
  - pred_target_o = pred_taken_o ? target[idx] : fetch_pc_i+4 (32-bit, wraps at 2^32).
- Redirect (combinational, execute stage):
  - redirect_o = upd_valid_i && ((upd_taken_i != upd_pred_taken_i) || (upd_taken_i && upd_target_i != upd_pred_target_i)).
  - redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4. It is driven regardless of redirect_o.
- Update, on clk_i rising edge when upd_valid_i=1:
  - Effective outcome: t = upd_taken_i | upd_uncond_i.
  - Hit, t=1: ctr saturating +1 (max 2'b11); target <= upd_target_i.
  - Hit, t=0: ctr saturating -1 (min 2'b00); target unchanged.
  - Hit, upd_uncond_i=1: ctr <= 2'b11.
  - Miss, t=1: allocate/overwrite: valid=1, tag, target, ctr=2'b10 (2'b11 if uncond).
  - Miss, t=0: no change (no allocation on not-taken).
- mispred_cnt_o increments by 1 on every cycle with redirect_o=1 and wraps from 32'hFFFF_FFFF to 0.
- Simultaneous lookup and update of the same index: lookup sees pre-update contents (no bypass). The new state is visible the following cycle.
- upd_valid_i=0: tables and counter hold; redirect_o=0.
- Reset (rst_ni low, asynchronous, any cycle including mid-update):
  - all valid=0, ctr=2'b01, target=0, tag=0, mispred_cnt_o=0.
  - Hence pred_taken_o=0 and pred_target_o=fetch_pc_i+4.
  - redirect_o is combinational and follows its inputs even during reset.
  - An update coincident with reset deassertion edge is ignored.
- Latency: prediction 0 cycles; training visible 1 cycle after the update edge.

Decomposition:
- Package branch_pkg holds:
  - ctr_t (logic [1:0])
  - constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11
  - typedef bp_entry_t (valid, tag, target, ctr), with the tag width supplied from the parameter via a packed struct in the module, or a max-width field in the package
- One natural sub-module: sat_counter2, a pure function/module computing the next 2-bit saturating state from (ctr, taken, force_strong).
- Table arrays and redirect logic stay in branch_predictor.

Test Plan:
- Reset then fetch_pc_i=32'h0000_0100 -> pred_taken_o=0, pred_target_o=32'h0000_0104, mispred_cnt_o=0.
- Update pc=32'h100, taken=1, target=32'h80, pred_taken=0 -> redirect_o=1, redirect_pc_o=32'h80, cnt=1. Next cycle fetch 32'h100 -> pred_taken_o=1, pred_target_o=32'h80.
- Entry at ctr=2'b10: two not-taken updates to 32'h100 -> ctr 01 then 00. Fetch predicts not taken; three taken updates saturate at 11.
- Alias: taken update pc=32'h100 then taken update pc=32'h140 (ENTRIES=16, same idx, different tag) -> fetch 32'h100 misses (pred_taken_o=0); fetch 32'h140 hits.
- Same-cycle fetch and update of 32'h200 (first taken) -> that cycle pred_taken_o=0; next cycle pred_taken_o=1.
- Taken with wrong target: upd_pred_taken=1, pred_target=32'h300, actual 32'h340 -> redirect_o=1, redirect_pc_o=32'h340. Assert rst_ni mid-run -> pred_taken_o=0 and cnt=0 immediately.
